ascon_arbiter: RTL and testbench

ASCON_ARBITER -- requirements
Module: ascon_arbiter

---
 rtl/ascon_arbiter_if.sv | 48 ++++
 rtl/ascon_arbiter.sv | 100 ++++++++++
 tb/tb_ascon_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ascon_arbiter_if.sv
// ascon_arbiter_if: requester-side and engine-side signals of the ASCON job arbiter
// slave  : arbiter view (requester/engine inputs in, status/engine controls out)
// master : environment view (drives requests and engine status, observes arbiter outputs)
interface ascon_arbiter_if #(
  parameter int NREQ      = 2,
  parameter int BUF_DEPTH = 4,
  parameter int BLK_AD_AW = 3,
  parameter int BLK_PT_AW = 3
);
  logic [NREQ-1:0]                           req_i;
  logic [NREQ-1:0][127:0]                    key_i;
  logic [NREQ-1:0][127:0]                    nonce_i;
  logic [NREQ-1:0][BLK_AD_AW-1:0]            ad_size_i;
  logic [NREQ-1:0][BLK_PT_AW-1:0]            pt_size_i;
  logic [NREQ-1:0][BUF_DEPTH-1:0][63:0]      data_i;
  logic [NREQ-1:0]                           data_valid_i;
  logic [NREQ-1:0]                           ct_read_ack_i;
  logic [NREQ-1:0]                           grant_o;
  logic [NREQ-1:0]                           done_o;
  logic [NREQ-1:0]                           data_req_o;
  logic [NREQ-1:0]                           ct_ready_o;
  logic [127:0]                              tag_o;
  logic                                      eng_start_o;
  logic                                      eng_data_valid_o;
  logic                                      eng_ct_read_ack_o;
  logic [127:0]                              eng_key_o;
  logic [127:0]                              eng_nonce_o;
  logic [BLK_AD_AW-1:0]                      eng_ad_size_o;
  logic [BLK_PT_AW-1:0]                      eng_pt_size_o;
  logic [BUF_DEPTH-1:0][63:0]                eng_data_o;
  logic                                      eng_ready_i;
  logic                                      eng_done_i;
  logic                                      eng_data_req_i;
  logic                                      eng_ct_ready_i;
  logic [127:0]                              eng_tag_i;
  modport slave (
    input  req_i, key_i, nonce_i, ad_size_i, pt_size_i, data_i, data_valid_i, ct_read_ack_i,
           eng_ready_i, eng_done_i, eng_data_req_i, eng_ct_ready_i, eng_tag_i,
    output grant_o, done_o, data_req_o, ct_ready_o, tag_o, eng_start_o, eng_data_valid_o,
           eng_ct_read_ack_o, eng_key_o, eng_nonce_o, eng_ad_size_o, eng_pt_size_o, eng_data_o
  );
  modport master (
    output req_i, key_i, nonce_i, ad_size_i, pt_size_i, data_i, data_valid_i, ct_read_ack_i,
           eng_ready_i, eng_done_i, eng_data_req_i, eng_ct_ready_i, eng_tag_i,
    input  grant_o, done_o, data_req_o, ct_ready_o, tag_o, eng_start_o, eng_data_valid_o,
           eng_ct_read_ack_o, eng_key_o, eng_nonce_o, eng_ad_size_o, eng_pt_size_o, eng_data_o
  );
endinterface

// File: rtl/ascon_arbiter.sv
// ascon_arbiter: round-robin sharing of one ASCON engine among NREQ requesters
// clk_i : clock
// rst_i : asynchronous active-high reset
// bus   : ascon_arbiter_if.slave carrying all requester and engine signals
module ascon_arbiter #(
  parameter int NREQ      = 2,
  parameter int BUF_DEPTH = 4,
  parameter int BLK_AD_AW = 3,
  parameter int BLK_PT_AW = 3
) (
  input logic            clk_i,
  input logic            rst_i,
  ascon_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;
  state_t               r_state;
  logic [OW-1:0]        r_owner, r_rr;
  logic [127:0]         r_key, r_nonce, r_tag;
  logic [BLK_AD_AW-1:0] r_ad;
  logic [BLK_PT_AW-1:0] r_pt;
  logic [NREQ-1:0]      r_grant, r_done;
  logic                 r_start;
  logic [2*NREQ-1:0]    w_dbl;
  logic [OW-1:0]        w_off, w_win;
  logic [OW:0]          w_sum, w_sub;
  logic                 w_busy, w_route;
  // Rotate requests so the search starts at rr_ptr; lowest set offset wins.
  always_comb begin
    w_dbl = {bus.req_i, bus.req_i} >> r_rr;
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_dbl[k]) w_off = OW'(k);
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    w_sub = w_sum - (OW + 1)'(NREQ);
    w_win = (w_sum >= (OW + 1)'(NREQ)) ? w_sub[OW-1:0] : w_sum[OW-1:0];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_key   <= '0;
      r_nonce <= '0;
      r_ad    <= '0;
      r_pt    <= '0;
      r_tag   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: if (|bus.req_i && bus.eng_ready_i) begin
          r_owner <= w_win;
          r_key   <= bus.key_i[w_win];
          r_nonce <= bus.nonce_i[w_win];
          r_ad    <= bus.ad_size_i[w_win];
          r_pt    <= bus.pt_size_i[w_win];
          r_grant <= NREQ'(1) << w_win;
          r_start <= 1'b1;
          r_state <= START;
        end
        START: begin
          r_start <= 1'b0;
          r_state <= BUSY;
        end
        BUSY: if (bus.eng_done_i) begin
          r_tag   <= bus.eng_tag_i;
          r_done  <= NREQ'(1) << r_owner;
          r_state <= RELEASE;
        end
        RELEASE: begin
          r_rr    <= (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Handshakes pass through only to/from the owner while the engine is busy.
  always_comb begin
    w_busy                = r_state == BUSY;
    w_route               = r_state == START || r_state == BUSY;
    bus.grant_o           = r_grant;
    bus.done_o            = r_done;
    bus.tag_o             = r_tag;
    bus.eng_start_o       = r_start;
    bus.eng_key_o         = r_key;
    bus.eng_nonce_o       = r_nonce;
    bus.eng_ad_size_o     = r_ad;
    bus.eng_pt_size_o     = r_pt;
    bus.eng_data_o        = w_route ? bus.data_i[r_owner] : '0;
    bus.data_req_o        = w_busy ? NREQ'(bus.eng_data_req_i) << r_owner : '0;
    bus.ct_ready_o        = w_busy ? NREQ'(bus.eng_ct_ready_i) << r_owner : '0;
    bus.eng_data_valid_o  = w_busy && bus.data_valid_i[r_owner];
    bus.eng_ct_read_ack_o = w_busy && bus.ct_read_ack_i[r_owner];
  end
endmodule

// File: tb/tb_ascon_arbiter.sv
// tb_ascon_arbiter: scenario tasks with a done/tag scoreboard for ascon_arbiter
module tb_ascon_arbiter;
  localparam int N  = 2;
  localparam int BD = 4;
  localparam int AW = 3;
  localparam int PW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct {int owner; logic [127:0] tag;} exp_t;
  exp_t sb[$];
  ascon_arbiter_if #(.NREQ(N), .BUF_DEPTH(BD), .BLK_AD_AW(AW), .BLK_PT_AW(PW)) bus ();
  ascon_arbiter #(.NREQ(N), .BUF_DEPTH(BD), .BLK_AD_AW(AW), .BLK_PT_AW(PW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] key_of(input int i);
    return {4{32'hC0DE_0000 + i}};
  endfunction
  function automatic logic [BD-1:0][63:0] data_of(input int i);
    logic [BD-1:0][63:0] d;
    for (int j = 0; j < BD; j++) d[j] = {32'hDA7A_0000 + i, 32'h0000_1000 + j};
    return d;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input int owner);
    step();
    checks++; if (bus.grant_o !== N'(1 << owner)) begin failures++; $display("FAIL start_grant got=%b exp=%b", bus.grant_o, N'(1 << owner)); end
    checks++; if (bus.eng_start_o !== 1'b1) begin failures++; $display("FAIL start_pulse got=%b exp=1", bus.eng_start_o); end
    checks++; if (bus.eng_key_o !== key_of(owner) || bus.eng_nonce_o !== ~key_of(owner)) begin failures++; $display("FAIL start_keynonce got=%h exp=%h", bus.eng_key_o, key_of(owner)); end
    checks++; if (bus.eng_ad_size_o !== AW'(owner + 1) || bus.eng_pt_size_o !== PW'(owner + 2)) begin failures++; $display("FAIL start_sizes got=%0d/%0d exp=%0d/%0d", bus.eng_ad_size_o, bus.eng_pt_size_o, owner + 1, owner + 2); end
    checks++; if (bus.eng_data_o !== data_of(owner)) begin failures++; $display("FAIL start_data got=%h exp=%h", bus.eng_data_o, data_of(owner)); end
    step();
    checks++; if (bus.eng_start_o !== 1'b0 || bus.grant_o !== N'(1 << owner)) begin failures++; $display("FAIL busy_entry got=start%b grant%b exp=start0 grant%b", bus.eng_start_o, bus.grant_o, N'(1 << owner)); end
  endtask
  task automatic finish_job(input int owner, input logic [127:0] tag);
    exp_t e;
    int n;
    e.owner = owner;
    e.tag = tag;
    sb.push_back(e);
    bus.eng_done_i = 1'b1;
    bus.eng_tag_i = tag;
    n = 0;
    do begin step(); n++; end while (bus.done_o == '0 && n < 4);
    bus.eng_done_i = 1'b0;
    bus.eng_tag_i = '0;
    checks++;
    if (bus.done_o == '0) begin
      failures++; $display("FAIL done_timeout got=%b exp=%b", bus.done_o, N'(1 << owner));
    end else begin
      e = sb.pop_front();
      if (bus.done_o !== N'(1 << e.owner) || bus.tag_o !== e.tag) begin failures++; $display("FAIL done_tag got=%b/%h exp=%b/%h", bus.done_o, bus.tag_o, N'(1 << e.owner), e.tag); end
    end
    checks++; if (bus.grant_o !== N'(1 << owner) || bus.data_req_o !== '0 || bus.eng_data_valid_o !== 1'b0) begin failures++; $display("FAIL release_outputs got=grant%b dreq%b dv%b", bus.grant_o, bus.data_req_o, bus.eng_data_valid_o); end
    step();
    checks++; if (bus.done_o !== '0 || bus.grant_o !== '0) begin failures++; $display("FAIL after_release got=done%b grant%b exp=00/00", bus.done_o, bus.grant_o); end
    checks++; if (bus.tag_o !== tag) begin failures++; $display("FAIL tag_hold got=%h exp=%h", bus.tag_o, tag); end
  endtask
  task automatic do_job(input int owner, input logic [127:0] tag);
    start_job(owner);
    finish_job(owner, tag);
  endtask
  task automatic test_reset();
    bus.req_i = 2'b11;
    bus.eng_ready_i = 1'b1;
    #1;
    checks++; if (bus.grant_o !== '0 || bus.eng_start_o !== 1'b0 || bus.done_o !== '0) begin failures++; $display("FAIL reset_ctrl got=grant%b start%b done%b", bus.grant_o, bus.eng_start_o, bus.done_o); end
    step();
    step();
    checks++; if (bus.grant_o !== '0 || bus.tag_o !== '0 || bus.eng_key_o !== '0) begin failures++; $display("FAIL reset_hold got=grant%b tag%h key%h", bus.grant_o, bus.tag_o, bus.eng_key_o); end
    checks++; if (bus.eng_data_o !== '0 || bus.data_req_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.eng_data_o); end
    rst = 1'b0;
  endtask
  task automatic test_round_robin();
    do_job(0, {16{8'hA5}});
  endtask
  task automatic test_routing();
    start_job(1);
    bus.eng_data_req_i = 1'b1;
    bus.data_valid_i = 2'b01;
    #1;
    checks++; if (bus.data_req_o !== 2'b10 || bus.eng_data_valid_o !== 1'b0) begin failures++; $display("FAIL route_nonowner got=dreq%b dv%b exp=10/0", bus.data_req_o, bus.eng_data_valid_o); end
    bus.data_valid_i = 2'b10;
    #1;
    checks++; if (bus.eng_data_valid_o !== 1'b1) begin failures++; $display("FAIL route_owner_dv got=%b exp=1", bus.eng_data_valid_o); end
    bus.eng_ct_ready_i = 1'b1;
    bus.ct_read_ack_i = 2'b01;
    #1;
    checks++; if (bus.ct_ready_o !== 2'b10 || bus.eng_ct_read_ack_o !== 1'b0) begin failures++; $display("FAIL route_ct_nonowner got=%b/%b exp=10/0", bus.ct_ready_o, bus.eng_ct_read_ack_o); end
    bus.ct_read_ack_i = 2'b10;
    bus.key_i[1] = ~key_of(1);
    #1;
    checks++; if (bus.eng_ct_read_ack_o !== 1'b1) begin failures++; $display("FAIL route_ct_ack got=%b exp=1", bus.eng_ct_read_ack_o); end
    checks++; if (bus.eng_key_o !== key_of(1)) begin failures++; $display("FAIL key_latched got=%h exp=%h", bus.eng_key_o, key_of(1)); end
    bus.key_i[1] = key_of(1);
    bus.req_i = 2'b00;
    step();
    step();
    checks++; if (bus.grant_o !== 2'b10 || bus.data_req_o !== 2'b10 || bus.ct_ready_o !== 2'b10) begin failures++; $display("FAIL req_drop got=grant%b dreq%b ctr%b exp=10", bus.grant_o, bus.data_req_o, bus.ct_ready_o); end
    finish_job(1, {16{8'h5A}});
    bus.eng_data_req_i = 1'b0;
    bus.eng_ct_ready_i = 1'b0;
    bus.data_valid_i = '0;
    bus.ct_read_ack_i = '0;
  endtask
  task automatic test_not_ready();
    int seen;
    seen = 0;
    bus.req_i = 2'b01;
    bus.eng_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.grant_o != '0 || bus.eng_start_o) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL not_ready_grant got=%0d exp=0", seen); end
    bus.eng_ready_i = 1'b1;
    do_job(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
  endtask
  task automatic test_reset_mid();
    bus.req_i = 2'b10;
    start_job(1);
    bus.eng_data_req_i = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus.grant_o !== '0 || bus.eng_start_o !== 1'b0 || bus.tag_o !== '0) begin failures++; $display("FAIL reset_async got=grant%b start%b tag%h", bus.grant_o, bus.eng_start_o, bus.tag_o); end
    checks++; if (bus.data_req_o !== '0 || bus.eng_key_o !== '0) begin failures++; $display("FAIL reset_async_route got=dreq%b key%h", bus.data_req_o, bus.eng_key_o); end
    bus.eng_data_req_i = 1'b0;
    step();
    rst = 1'b0;
    bus.req_i = 2'b11;
    do_job(0, {4{32'hDEAD_BEEF}});
  endtask
  task automatic test_back_to_back();
    bus.req_i = 2'b11;
    do_job(1, {8{16'h1111}});
    do_job(0, {8{16'h2222}});
    do_job(1, {8{16'h3333}});
    bus.req_i = 2'b00;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
  endtask
  initial begin
    bus.req_i = '0;
    bus.data_valid_i = '0;
    bus.ct_read_ack_i = '0;
    bus.eng_ready_i = 1'b0;
    bus.eng_done_i = 1'b0;
    bus.eng_data_req_i = 1'b0;
    bus.eng_ct_ready_i = 1'b0;
    bus.eng_tag_i = '0;
    for (int i = 0; i < N; i++) begin
      bus.key_i[i] = key_of(i);
      bus.nonce_i[i] = ~key_of(i);
      bus.ad_size_i[i] = AW'(i + 1);
      bus.pt_size_i[i] = PW'(i + 2);
      bus.data_i[i] = data_of(i);
    end
    test_reset();
    test_round_robin();
    test_routing();
    test_not_ready();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
